// File: rtl/core_pkg.sv
// Shared core types and constants used by the fetch stage and decode.
// Provides the fetch-to-decode payload (if_id_t), the canonical NOP,
// the default reset PC, the fetch FSM state type and a word-align helper.
package core_pkg;

   localparam int unsigned CORE_XLEN = 32;
   localparam int unsigned ILEN      = 32;

   localparam logic [ILEN-1:0]      NOP_INSTR        = 32'h0000_0013;   // addi x0, x0, 0
   localparam logic [CORE_XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Payload handed from fetch to decode.
   typedef struct packed {
      logic [ILEN-1:0]      instr;
      logic [CORE_XLEN-1:0] pc;
      logic [CORE_XLEN-1:0] pc4;
   } if_id_t;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } fetch_state_t;

   // Clears the two low address bits so every fetch is word aligned.
   function automatic logic [CORE_XLEN-1:0] alignWord(input logic [CORE_XLEN-1:0] addr);
      return {addr[CORE_XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer between instruction memory and decode.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   flush         discard all entries (wins over push/pop)
//   push/pushData write one if_id_t entry
//   pop           retire the head entry
//   headData      current head entry (valid when !empty)
//   count         number of buffered entries
//   full, empty   occupancy flags
module fetch_fifo
   import core_pkg::*;
#(
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  if_id_t        pushData,
   input  logic          pop,
   output if_id_t        headData,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   if_id_t        mem [DEPTH];
   logic [AW-1:0] rdPtr;
   logic [AW-1:0] wrPtr;

   // Pointer and occupancy state; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else if (flush) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + AW'(1);
         if (pop)  rdPtr <= rdPtr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Storage needs no reset: entries are only observed while count is non-zero.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wrPtr] <= pushData;
   end

   assign headData = mem[rdPtr];
   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word requests to instruction
// memory, buffers responses in fetch_fifo and presents {instr, pc, pc+4} to
// decode over a valid/ready handshake. Redirects flush everything fetched so far.
// Optional build macro FETCH_BYPASS_EN: a response arriving while the buffer is
// empty is forwarded to decode in the same cycle (1-cycle request-to-valid).
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   imem_req_o/addr_o     fetch request and word-aligned address
//   imem_gnt_i            request accepted this cycle
//   imem_rvalid_i/rdata_i response, exactly one cycle after the grant
//   redirect_i/pc_i       take a new PC (branch/jump resolution)
//   if_valid_o/instr_o    instruction to decode (NOP when not valid)
//   if_pc_o/if_pc4_o      PC of the instruction and PC + 4
//   id_ready_i            decode accepts this cycle
module fetch_unit
   import core_pkg::*;
#(
   parameter int unsigned      XLEN       = CORE_XLEN,
   parameter logic [XLEN-1:0]  RESET_PC   = RESET_PC_DEFAULT,
   parameter int unsigned      FIFO_DEPTH = 2
) (
   input  logic            clk_i,
   input  logic            rst_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [31:0]     imem_rdata_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            if_valid_o,
   output logic [31:0]     if_instr_o,
   output logic [XLEN-1:0] if_pc_o,
   output logic [XLEN-1:0] if_pc4_o,
   input  logic            id_ready_i
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned SW = CW + 1;

   fetch_state_t    state;
   fetch_state_t    stateNext;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] reqPc;
   logic            inflight;
   logic            drop;

   logic            grant;
   logic            transfer;
   logic            respValid;
   logic [SW-1:0]   credit;

   logic            fifoPush;
   logic            fifoPop;
   logic            fifoFull;
   logic            fifoEmpty;
   logic [CW-1:0]   fifoCount;
   if_id_t          head;
   if_id_t          respEntry;
   if_id_t          outEntry;
   logic            outValid;

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk_i),
      .rst      (rst_i),
      .flush    (redirect_i),
      .push     (fifoPush),
      .pushData (respEntry),
      .pop      (fifoPop),
      .headData (head),
      .count    (fifoCount),
      .full     (fifoFull),
      .empty    (fifoEmpty)
   );

   // FSM state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= BOOT;
      else       state <= stateNext;
   end

   // Entries already buffered plus the one arriving, minus the one leaving this cycle.
   assign credit = SW'(fifoCount) + SW'(inflight) - SW'(transfer);

   // Next-state and request generation; requests are suppressed in the redirect cycle.
   always_comb begin
      stateNext  = state;
      imem_req_o = 1'b0;
      case (state)
         BOOT: stateNext = RUN;
         RUN:  imem_req_o = !redirect_i && (credit < SW'(FIFO_DEPTH));
         default: stateNext = BOOT;
      endcase
   end

   assign imem_addr_o = pc;
   assign grant       = imem_req_o & imem_gnt_i;

   // Gating with inflight ignores any response not matched to a grant of ours,
   // e.g. one arriving during or just after reset.
   assign respValid = imem_rvalid_i & inflight & ~drop;

   always_comb begin
      respEntry.instr = imem_rdata_i;
      respEntry.pc    = reqPc;
      respEntry.pc4   = reqPc + XLEN'(4);
   end

`ifdef FETCH_BYPASS_EN
   logic bypass;
   assign bypass = fifoEmpty & respValid & ~redirect_i;
`endif

   // Decode-side outputs and buffer control.
   always_comb begin
      outEntry = head;
      outValid = ~fifoEmpty;
      fifoPush = respValid & ~redirect_i;
`ifdef FETCH_BYPASS_EN
      if (bypass) begin
         outEntry = respEntry;
         outValid = 1'b1;
      end
`endif
      if_valid_o = outValid & ~redirect_i;
      transfer   = if_valid_o & id_ready_i;
`ifdef FETCH_BYPASS_EN
      fifoPop = transfer & ~bypass;
      if (bypass && id_ready_i) fifoPush = 1'b0;
`else
      fifoPop = transfer;
`endif
      fifoPush   = fifoPush & (~fifoFull | fifoPop);
      if_instr_o = if_valid_o ? outEntry.instr : NOP_INSTR;
      if_pc_o    = if_valid_o ? outEntry.pc    : pc;
      if_pc4_o   = if_valid_o ? outEntry.pc4   : pc + XLEN'(4);
   end

   // PC, request-PC and in-flight tracking; redirect has highest priority.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pc       <= RESET_PC;
         reqPc    <= RESET_PC;
         inflight <= 1'b0;
         drop     <= 1'b0;
      end else begin
         if (redirect_i)  pc <= alignWord(redirect_pc_i);
         else if (grant)  pc <= pc + XLEN'(4);
         if (grant) reqPc <= pc;
         inflight <= grant;
         // A word granted alongside a redirect belongs to the old path.
         drop     <= redirect_i & grant;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a one-cycle-latency instruction memory model,
// an expected-PC queue filled by the stimulus, and a monitor that checks every
// decode transfer against it.
module tb_fetch_unit;
   import core_pkg::*;

   localparam int unsigned XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_i;
   logic            imem_req_o;
   logic [XLEN-1:0] imem_addr_o;
   logic            imem_gnt_i;
   logic            imem_rvalid_i = 1'b0;
   logic [31:0]     imem_rdata_i  = 32'h0;
   logic            redirect_i;
   logic [XLEN-1:0] redirect_pc_i;
   logic            if_valid_o;
   logic [31:0]     if_instr_o;
   logic [XLEN-1:0] if_pc_o;
   logic [XLEN-1:0] if_pc4_o;
   logic            id_ready_i;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] expQ [$];
   logic [31:0] expPc;

   always #5 clk = ~clk;

   fetch_unit #(
      .XLEN       (XLEN),
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (2)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .if_valid_o    (if_valid_o),
      .if_instr_o    (if_instr_o),
      .if_pc_o       (if_pc_o),
      .if_pc4_o      (if_pc4_o),
      .id_ready_i    (id_ready_i)
   );

   function automatic logic [31:0] wordAt(input logic [31:0] addr);
      return addr ^ 32'h1357_9BDF;
   endfunction

   // Memory model: answers every accepted request exactly one cycle later.
   always @(posedge clk) begin
      imem_rvalid_i <= imem_req_o & imem_gnt_i & ~rst_i;
      imem_rdata_i  <= wordAt(imem_addr_o);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Monitor: every decode transfer must match the next expected PC.
   always @(negedge clk) begin
      if (!rst_i) begin
         if (if_valid_o && id_ready_i) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL xfer_unexpected actual=%h required=none", if_pc_o);
            end else begin
               expPc = expQ.pop_front();
               check("xfer_pc", if_pc_o, expPc);
               check("xfer_pc4", if_pc4_o, expPc + 32'd4);
               check("xfer_instr", if_instr_o, wordAt(expPc));
            end
         end else if (!if_valid_o) begin
            check("idle_nop", if_instr_o, NOP_INSTR);
         end
      end
   end

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic pushRange(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) expQ.push_back(base + 32'(4 * i));
   endtask

   task automatic checkReset();
      check("rst_req", 32'(imem_req_o), 32'd0);
      check("rst_addr", imem_addr_o, 32'h0);
      check("rst_valid", 32'(if_valid_o), 32'd0);
      check("rst_instr", if_instr_o, NOP_INSTR);
      check("rst_pc", if_pc_o, 32'h0);
      check("rst_pc4", if_pc4_o, 32'h4);
   endtask

   task automatic checkReq(input string name, input logic req, input logic [31:0] addr);
      check({name, "_req"}, 32'(imem_req_o), 32'(req));
      if (req) check({name, "_addr"}, imem_addr_o, addr);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      rst_i         = 1'b1;
      imem_gnt_i    = 1'b1;
      id_ready_i    = 1'b1;
      redirect_i    = 1'b0;
      redirect_pc_i = '0;
      repeat (2) @(posedge clk);
      #1;
      checkReset();
      // Stream from reset: 13 transfers (0x00..0x30) happen before the redirect.
      pushRange(32'h0, 13);
      rst_i = 1'b0;
      @(negedge clk); checkReq("boot", 1'b0, 32'h0);
      nextCycle(); @(negedge clk); checkReq("c1", 1'b1, 32'h0);
      nextCycle(); @(negedge clk); checkReq("c2", 1'b1, 32'h4);
      // Grant withheld for three cycles while the address sits at 0x8.
      nextCycle(); imem_gnt_i = 1'b0;
      @(negedge clk);
      checkReq("gnt0_a", 1'b1, 32'h8);
      check("first_valid", 32'(if_valid_o), 32'd1);
      check("first_pc", if_pc_o, 32'h0);
      nextCycle(); @(negedge clk); checkReq("gnt0_b", 1'b1, 32'h8);
      nextCycle(); @(negedge clk); checkReq("gnt0_c", 1'b1, 32'h8);
      nextCycle(); imem_gnt_i = 1'b1;
      @(negedge clk); checkReq("gnt1_a", 1'b1, 32'h8);
      nextCycle(); @(negedge clk); checkReq("gnt1_b", 1'b1, 32'hC);
      repeat (2) nextCycle();
      // Decode stalls for six cycles: credits run out and requests stop.
      nextCycle(); id_ready_i = 1'b0;
      @(negedge clk); checkReq("stall_a", 1'b0, 32'h0);
      repeat (5) nextCycle();
      @(negedge clk);
      checkReq("stall_b", 1'b0, 32'h0);
      check("stall_valid", 32'(if_valid_o), 32'd1);
      check("stall_pc", if_pc_o, 32'h10);
      nextCycle(); id_ready_i = 1'b1;
      @(negedge clk); checkReq("release", 1'b1, 32'h18);
      repeat (8) nextCycle();
      // Redirect to 0x103 while one entry is buffered and a response arrives.
      nextCycle();
      check("drain_stream", 32'(expQ.size()), 32'd0);
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0000_0103;
      pushRange(32'h100, 7);
      @(negedge clk);
      check("redir_valid", 32'(if_valid_o), 32'd0);
      checkReq("redir", 1'b0, 32'h0);
      nextCycle(); redirect_i = 1'b0;
      @(negedge clk); checkReq("redir_tgt", 1'b1, 32'h100);
      repeat (8) nextCycle();
      // Back-to-back redirects: only the second target is fetched.
      nextCycle();
      check("drain_redir", 32'(expQ.size()), 32'd0);
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0000_0200;
      @(negedge clk); check("b2b_valid", 32'(if_valid_o), 32'd0);
      nextCycle();
      redirect_pc_i = 32'h0000_0300;
      pushRange(32'h300, 6);
      @(negedge clk); checkReq("b2b_b", 1'b0, 32'h0);
      nextCycle(); redirect_i = 1'b0;
      @(negedge clk); checkReq("b2b_tgt", 1'b1, 32'h300);
      repeat (7) nextCycle();
      // Asynchronous reset pulse between clock edges.
      nextCycle();
      check("drain_b2b", 32'(expQ.size()), 32'd0);
      #2 rst_i = 1'b1;
      #1 checkReset();
      pushRange(32'h0, 10);
      nextCycle(); rst_i = 1'b0;
      @(negedge clk); checkReq("reboot", 1'b0, 32'h0);
      nextCycle(); @(negedge clk); checkReq("restart", 1'b1, 32'h0);
      repeat (11) nextCycle();
      nextCycle(); id_ready_i = 1'b0;
      repeat (3) nextCycle();
      check("drain_final", 32'(expQ.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
